idu_stage: RTL and testbench

Registered instruction-decode stage for the RV32I NPC core. Takes a fetched instruction and its PC through a valid/ready handshake and decodes it into the ALU control encoding (ctr, A-source, B-source, immediate) plus register, memory, branch and trap controls. Results are held in a single-entry pipeline register facing the execute stage. This stage is the producer of every ALU control input.

---
 rtl/idu_stage.sv | 198 +++++++++++++++++++
 tb/tb_idu_stage.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/idu_stage.sv
// RV32I instruction-decode stage: decodes inst/pc into ALU, register, memory,
// branch and trap controls held in a single-entry valid/ready pipeline register.
module idu_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] inst,
  input  logic [31:0] pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [3:0]  alu_ctr,
  output logic        alu_asrc,
  output logic [1:0]  alu_bsrc,
  output logic [31:0] imm,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [4:0]  rd,
  output logic        reg_wen,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic [2:0]  funct3,
  output logic        branch,
  output logic        jump,
  output logic        jalr,
  output logic        ebreak,
  output logic        illegal
);

  localparam logic [6:0]  OP_LUI    = 7'b0110111;
  localparam logic [6:0]  OP_AUIPC  = 7'b0010111;
  localparam logic [6:0]  OP_JAL    = 7'b1101111;
  localparam logic [6:0]  OP_JALR   = 7'b1100111;
  localparam logic [6:0]  OP_BRANCH = 7'b1100011;
  localparam logic [6:0]  OP_LOAD   = 7'b0000011;
  localparam logic [6:0]  OP_STORE  = 7'b0100011;
  localparam logic [6:0]  OP_IMM    = 7'b0010011;
  localparam logic [6:0]  OP_REG    = 7'b0110011;
  localparam logic [6:0]  OP_SYSTEM = 7'b1110011;
  localparam logic [31:0] INST_EBREAK = 32'h0010_0073;

  typedef struct packed {
    logic [31:0] pc;
    logic [3:0]  ctr;
    logic        asrc;
    logic [1:0]  bsrc;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        wen;
    logic        mem_rd;
    logic        mem_wr;
    logic [2:0]  funct3;
    logic        branch;
    logic        jump;
    logic        jalr;
    logic        ebreak;
    logic        illegal;
  } dec_t;

  dec_t        dec_c;
  dec_t        dec_q;
  logic        valid_q;
  logic        accept;
  logic [31:0] imm_i;
  logic [31:0] imm_s;
  logic [31:0] imm_b;
  logic [31:0] imm_u;
  logic [31:0] imm_j;
  logic [2:0]  f3;
  logic        alt;

  assign f3    = inst[14:12];
  assign alt   = inst[30];
  assign imm_i = {{20{inst[31]}}, inst[31:20]};
  assign imm_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
  assign imm_b = {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
  assign imm_u = {inst[31:12], 12'b0};
  assign imm_j = {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};

  // Combinational decode of the presented instruction; only registered on accept.
  always_comb begin
    dec_c        = '0;
    dec_c.pc     = pc;
    dec_c.rs1    = inst[19:15];
    dec_c.rs2    = inst[24:20];
    dec_c.rd     = inst[11:7];
    dec_c.funct3 = f3;
    case (inst[6:0])
      OP_LUI: begin
        dec_c.ctr  = 4'b0011;
        dec_c.bsrc = 2'b01;
        dec_c.imm  = imm_u;
        dec_c.wen  = 1'b1;
      end
      OP_AUIPC: begin
        dec_c.asrc = 1'b1;
        dec_c.bsrc = 2'b01;
        dec_c.imm  = imm_u;
        dec_c.wen  = 1'b1;
      end
      OP_JAL, OP_JALR: begin
        dec_c.asrc = 1'b1;
        dec_c.bsrc = 2'b10;
        dec_c.imm  = (inst[6:0] == OP_JAL) ? imm_j : imm_i;
        dec_c.jump = 1'b1;
        dec_c.jalr = (inst[6:0] == OP_JALR);
        dec_c.wen  = 1'b1;
      end
      OP_BRANCH: begin
        case (f3)
          3'b000, 3'b001: dec_c.ctr = 4'b1000;
          3'b100, 3'b101: dec_c.ctr = 4'b0010;
          3'b110, 3'b111: dec_c.ctr = 4'b1010;
          default:        dec_c.illegal = 1'b1;
        endcase
        if (!dec_c.illegal) begin
          dec_c.imm    = imm_b;
          dec_c.branch = 1'b1;
        end
      end
      OP_LOAD: begin
        dec_c.bsrc   = 2'b01;
        dec_c.imm    = imm_i;
        dec_c.mem_rd = 1'b1;
        dec_c.wen    = 1'b1;
      end
      OP_STORE: begin
        dec_c.bsrc   = 2'b01;
        dec_c.imm    = imm_s;
        dec_c.mem_wr = 1'b1;
      end
      OP_IMM: begin
        dec_c.bsrc = 2'b01;
        dec_c.imm  = imm_i;
        dec_c.wen  = 1'b1;
        case (f3)
          3'b011:  dec_c.ctr = 4'b1010;
          3'b101:  dec_c.ctr = {alt, 3'b101};
          default: dec_c.ctr = {1'b0, f3};
        endcase
      end
      OP_REG: begin
        dec_c.wen = 1'b1;
        case (f3)
          3'b000:  dec_c.ctr = {alt, 3'b000};
          3'b011:  dec_c.ctr = 4'b1010;
          3'b101:  dec_c.ctr = {alt, 3'b101};
          default: dec_c.ctr = {1'b0, f3};
        endcase
      end
      OP_SYSTEM: begin
        if (inst == INST_EBREAK) dec_c.ebreak  = 1'b1;
        else                     dec_c.illegal = 1'b1;
      end
      default: dec_c.illegal = 1'b1;
    endcase
    if (dec_c.rd == 5'd0) dec_c.wen = 1'b0;
  end

  assign in_ready = !valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  // Single-entry pipeline register; a drain and an accept in the same cycle overwrite.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      dec_q   <= '0;
    end else if (accept) begin
      valid_q <= 1'b1;
      dec_q   <= dec_c;
    end else if (out_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign out_valid = valid_q;
  assign out_pc    = dec_q.pc;
  assign alu_ctr   = dec_q.ctr;
  assign alu_asrc  = dec_q.asrc;
  assign alu_bsrc  = dec_q.bsrc;
  assign imm       = dec_q.imm;
  assign rs1       = dec_q.rs1;
  assign rs2       = dec_q.rs2;
  assign rd        = dec_q.rd;
  assign reg_wen   = dec_q.wen;
  assign mem_rd    = dec_q.mem_rd;
  assign mem_wr    = dec_q.mem_wr;
  assign funct3    = dec_q.funct3;
  assign branch    = dec_q.branch;
  assign jump      = dec_q.jump;
  assign jalr      = dec_q.jalr;
  assign ebreak    = dec_q.ebreak;
  assign illegal   = dec_q.illegal;

endmodule

// File: tb/tb_idu_stage.sv
// Bench for idu_stage: directed test-plan steps plus randomized traffic
// checked against an instruction-level reference decoder and handshake model.
module tb_idu_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] inst;
  logic [31:0] pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [3:0]  alu_ctr;
  logic        alu_asrc;
  logic [1:0]  alu_bsrc;
  logic [31:0] imm;
  logic [4:0]  rs1, rs2, rd;
  logic        reg_wen, mem_rd, mem_wr;
  logic [2:0]  funct3;
  logic        branch, jump, jalr, ebreak, illegal;

  int errors = 0;
  int checks = 0;

  logic        exp_valid;
  logic [96:0] exp_pl;
  logic [96:0] obs_pl;

  idu_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .inst(inst), .pc(pc), .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .alu_ctr(alu_ctr), .alu_asrc(alu_asrc), .alu_bsrc(alu_bsrc),
    .imm(imm), .rs1(rs1), .rs2(rs2), .rd(rd), .reg_wen(reg_wen),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .funct3(funct3), .branch(branch),
    .jump(jump), .jalr(jalr), .ebreak(ebreak), .illegal(illegal)
  );

  always #5 clk = ~clk;

  assign obs_pl = {out_pc, alu_ctr, alu_asrc, alu_bsrc, imm, rs1, rs2, rd,
                   reg_wen, mem_rd, mem_wr, funct3, branch, jump, jalr, ebreak, illegal};

  // Reference decoder, organised by instruction class and mnemonic.
  function automatic logic [96:0] ref_decode(input logic [31:0] i, input logic [31:0] p);
    logic signed [31:0] si;
    logic [31:0] im_i, im_s, im_b, im_u, im_j, im;
    logic [3:0]  ctr;
    logic        asrc, wen, mrd, mwr, br, jp, jr, eb, ill;
    logic [1:0]  bsrc;
    logic [2:0]  f3;
    si   = i;
    im_i = 32'(si >>> 20);
    im_s = {im_i[31:5], i[11:7]};
    im_b = {{20{i[31]}}, i[7], i[30:25], i[11:8], 1'b0};
    im_u = i & 32'hFFFF_F000;
    im_j = {{12{i[31]}}, i[19:12], i[20], i[30:21], 1'b0};
    f3   = i[14:12];
    ctr = 4'd0; asrc = 1'b0; bsrc = 2'd0; im = 32'd0;
    wen = 1'b0; mrd = 1'b0; mwr = 1'b0; br = 1'b0; jp = 1'b0; jr = 1'b0; eb = 1'b0; ill = 1'b0;
    case (i[6:0])
      7'h37: begin ctr = 4'b0011; bsrc = 2'd1; im = im_u; wen = 1'b1; end
      7'h17: begin asrc = 1'b1; bsrc = 2'd1; im = im_u; wen = 1'b1; end
      7'h6F: begin asrc = 1'b1; bsrc = 2'd2; im = im_j; jp = 1'b1; wen = 1'b1; end
      7'h67: begin asrc = 1'b1; bsrc = 2'd2; im = im_i; jp = 1'b1; jr = 1'b1; wen = 1'b1; end
      7'h63: begin
        if (f3 == 3'd2 || f3 == 3'd3) ill = 1'b1;
        else begin
          br  = 1'b1;
          im  = im_b;
          ctr = (f3 < 3'd2) ? 4'b1000 : (f3 < 3'd6) ? 4'b0010 : 4'b1010;
        end
      end
      7'h03: begin bsrc = 2'd1; im = im_i; mrd = 1'b1; wen = 1'b1; end
      7'h23: begin bsrc = 2'd1; im = im_s; mwr = 1'b1; end
      7'h13: begin
        bsrc = 2'd1; im = im_i; wen = 1'b1;
        ctr  = (f3 == 3'd3) ? 4'b1010 : (f3 == 3'd5) ? {i[30], 3'b101} : {1'b0, f3};
      end
      7'h33: begin
        wen = 1'b1;
        ctr = (f3 == 3'd3) ? 4'b1010 : (f3 == 3'd0 || f3 == 3'd5) ? {i[30], f3} : {1'b0, f3};
      end
      7'h73: begin
        if (i == 32'h0010_0073) eb = 1'b1;
        else ill = 1'b1;
      end
      default: ill = 1'b1;
    endcase
    if (i[11:7] == 5'd0) wen = 1'b0;
    return {p, ctr, asrc, bsrc, im, i[19:15], i[24:20], i[11:7],
            wen, mrd, mwr, f3, br, jp, jr, eb, ill};
  endfunction

  task automatic chk(input string tag, input logic [96:0] obs, input logic [96:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs at negedge, check in_ready, then check registered outputs.
  task automatic step(input logic iv, input logic [31:0] ins, input logic [31:0] p,
                      input logic ordy, input string tag);
    logic acc;
    @(negedge clk);
    rst = 1'b0; in_valid = iv; inst = ins; pc = p; out_ready = ordy;
    #1;
    chk({tag, ":in_ready"}, 97'(in_ready), 97'(!exp_valid || ordy));
    acc = iv && (!exp_valid || ordy);
    @(posedge clk);
    if (acc) begin
      exp_valid = 1'b1;
      exp_pl    = ref_decode(ins, p);
    end else if (ordy) begin
      exp_valid = 1'b0;
    end
    #1;
    chk({tag, ":out_valid"}, 97'(out_valid), 97'(exp_valid));
    chk({tag, ":payload"}, obs_pl, exp_pl);
  endtask

  task automatic do_reset(input logic iv, input logic ordy, input string tag);
    @(negedge clk);
    rst = 1'b1; in_valid = iv; out_ready = ordy; inst = 32'h0010_0093; pc = 32'h1234;
    @(posedge clk);
    exp_valid = 1'b0;
    exp_pl    = '0;
    #1;
    chk({tag, ":out_valid"}, 97'(out_valid), 97'(1'b0));
    chk({tag, ":payload"}, obs_pl, 97'(0));
  endtask

  logic [6:0]  ops [12];
  logic [31:0] r, ri, rp;
  logic [96:0] snap;

  initial begin
    ops = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h73, 7'h13, 7'h33};
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; inst = '0; pc = '0;
    exp_valid = 1'b0; exp_pl = '0;
    do_reset(1'b0, 1'b0, "reset0");

    step(1'b1, 32'h0050_0093, 32'h0000_0100, 1'b1, "addi");
    chk("addi_ctr",  97'(alu_ctr),  97'(4'b0000));
    chk("addi_bsrc", 97'(alu_bsrc), 97'(2'b01));
    chk("addi_imm",  97'(imm),      97'(32'h5));
    chk("addi_rd_wen", 97'({rd, reg_wen}), 97'({5'd1, 1'b1}));

    step(1'b1, 32'h4020_81B3, 32'h0000_0104, 1'b1, "sub");
    chk("sub_ctr", 97'({alu_ctr, alu_bsrc, rd}), 97'({4'b1000, 2'b00, 5'd3}));
    step(1'b1, 32'h4073_52B3, 32'h0000_0108, 1'b1, "sra");
    chk("sra_ctr", 97'({out_valid, alu_ctr, rd}), 97'({1'b1, 4'b1101, 5'd5}));

    step(1'b1, 32'hFFF0_B113, 32'h0000_010C, 1'b1, "sltiu");
    chk("sltiu_ctr_imm", 97'({alu_ctr, imm}), 97'({4'b1010, 32'hFFFF_FFFF}));
    step(1'b1, 32'h0080_00EF, 32'h8000_0000, 1'b1, "jal");
    chk("jal_fields", 97'({alu_asrc, alu_bsrc, imm, jump, out_pc}),
        97'({1'b1, 2'b10, 32'h8, 1'b1, 32'h8000_0000}));

    // Stall with a pending new instruction, then release.
    step(1'b1, 32'h0050_0093, 32'h0000_0200, 1'b0, "stall_acc");
    snap = obs_pl;
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 32'h00A0_0113, 32'h0000_0204, 1'b0, "stall");
      chk("stall_hold", obs_pl, snap);
    end
    step(1'b1, 32'h00A0_0113, 32'h0000_0204, 1'b1, "stall_release");
    chk("release_rd", 97'(rd), 97'(5'd2));

    step(1'b1, 32'h0000_0013, 32'h0000_0300, 1'b1, "nop");
    chk("nop_wen", 97'(reg_wen), 97'(1'b0));
    step(1'b1, 32'hFFFF_FFFF, 32'h0000_0304, 1'b1, "illegal");
    chk("illegal_flags", 97'({illegal, reg_wen, mem_rd, mem_wr, branch, jump, jalr, alu_ctr}),
        97'({1'b1, 10'd0}));
    step(1'b1, 32'h0010_0073, 32'h0000_0308, 1'b1, "ebreak");
    chk("ebreak_flag", 97'({ebreak, reg_wen}), 97'({1'b1, 1'b0}));
    step(1'b0, 32'h0, 32'h0, 1'b1, "drain");

    // Reset asserted in the middle of a stall.
    step(1'b1, 32'h0050_0093, 32'h0000_0400, 1'b0, "pre_rst");
    step(1'b1, 32'h00A0_0113, 32'h0000_0404, 1'b0, "pre_rst_stall");
    do_reset(1'b1, 1'b0, "rst_stall");
    step(1'b0, 32'h0, 32'h0, 1'b0, "post_rst");

    for (int n = 0; n < 400; n++) begin
      r  = $urandom;
      ri = $urandom;
      rp = $urandom;
      ri = {ri[31:7], ops[r[3:0] % 12]};
      if (r[9:6] == 4'd0) ri = 32'h0010_0073;
      if (r[9:6] == 4'd1) ri = 32'hFFFF_FFFF;
      if (r[9:6] == 4'd2) ri = {ri[31:7], r[16:10]};
      step(r[4] | r[5], ri, {rp[31:2], 2'b00}, r[17] | r[18], "rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
